persp_divide: RTL

Perspective-divide stage placed directly downstream of the vertex transform stage. It accepts one transformed triangle (three vertices of Q16.16 x/y/z/w), divides x, y and z of each vertex by that vertex's w with a single shared iterative divider, and presents normalized Q16.16 coordinates to the rasterizer setup stage. It uses the pipeline's valid/stall/done handshake on both sides.

---
 rtl/persp_divide_if.sv | 27 ++
 rtl/persp_divide.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/persp_divide_if.sv
// rtl/persp_divide_if.sv - vertex-in / screen-coordinate-out bus for the perspective-divide stage
interface persp_divide_if;
  logic [3:0][31:0] x_in;
  logic [3:0][31:0] y_in;
  logic [3:0][31:0] z_in;
  logic [3:0][31:0] w_in;
  logic             in_data_valid;
  logic             done_in;
  logic             stall_in;
  logic [2:0][31:0] sx_out;
  logic [2:0][31:0] sy_out;
  logic [2:0][31:0] sz_out;
  logic             clip_out;
  logic             out_data_valid;
  logic             stall_out;
  logic             done_out;

  modport slave (
    input  x_in, y_in, z_in, w_in, in_data_valid, done_in, stall_in,
    output sx_out, sy_out, sz_out, clip_out, out_data_valid, stall_out, done_out
  );

  modport master (
    output x_in, y_in, z_in, w_in, in_data_valid, done_in, stall_in,
    input  sx_out, sy_out, sz_out, clip_out, out_data_valid, stall_out, done_out
  );
endinterface

// File: rtl/persp_divide.sv
// rtl/persp_divide.sv - per-vertex x/w, y/w, z/w with one shared restoring divider
module persp_divide #(
  parameter int DIV_BITS = 48
) (
  input  logic           clock,
  input  logic           reset,
  persp_divide_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, PREP, DIV, OUT} state_t;

  state_t              state_q, state_d;
  logic [3:0]          k_q, k_d;
  logic [5:0]          cnt_q, cnt_d;
  logic [2:0][31:0]    x_q, x_d, y_q, y_d, z_q, z_d, w_q, w_d;
  logic [DIV_BITS-1:0] dvd_q, dvd_d;   // dividend shifts out MSB-first, quotient shifts in
  logic [31:0]         dvs_q, dvs_d;
  logic [31:0]         rem_q, rem_d;
  logic                sign_q, sign_d;
  logic [2:0][31:0]    sx_q, sx_d, sy_q, sy_d, sz_q, sz_d;
  logic                clip_q, clip_d;
  logic                valid_q, valid_d;
  logic                stall_q, stall_d;
  logic                done_q, done_d;

  logic [1:0]          vsel, csel;
  logic [31:0]         n_cur, w_cur, n_mag, w_mag;
  logic [32:0]         rem_sh;
  logic [31:0]         rem_sub;
  logic                qbit;
  logic [DIV_BITS-1:0] q_fin;
  logic                q_big;
  logic [31:0]         res;

  // Lane 3 of each coordinate bus is a pad lane and carries nothing.
  logic unused_lane3;
  assign unused_lane3 = &{1'b0, bus.x_in[3], bus.y_in[3], bus.z_in[3], bus.w_in[3]};

  // Map element index k onto (vertex, component) and pick its numerator/divisor.
  always_comb begin
    vsel = 2'd0;
    csel = 2'd0;
    case (k_q)
      4'd1:    begin vsel = 2'd0; csel = 2'd1; end
      4'd2:    begin vsel = 2'd0; csel = 2'd2; end
      4'd3:    begin vsel = 2'd1; csel = 2'd0; end
      4'd4:    begin vsel = 2'd1; csel = 2'd1; end
      4'd5:    begin vsel = 2'd1; csel = 2'd2; end
      4'd6:    begin vsel = 2'd2; csel = 2'd0; end
      4'd7:    begin vsel = 2'd2; csel = 2'd1; end
      4'd8:    begin vsel = 2'd2; csel = 2'd2; end
      default: begin vsel = 2'd0; csel = 2'd0; end
    endcase
    case (csel)
      2'd0:    n_cur = x_q[vsel];
      2'd1:    n_cur = y_q[vsel];
      default: n_cur = z_q[vsel];
    endcase
    w_cur = w_q[vsel];
    n_mag = n_cur[31] ? (~n_cur + 32'd1) : n_cur;
    w_mag = w_cur[31] ? (~w_cur + 32'd1) : w_cur;
  end

  // One restoring step plus the signed/saturated result of the finishing element.
  always_comb begin
    rem_sh  = {rem_q, dvd_q[DIV_BITS-1]};
    rem_sub = rem_sh[31:0] - dvs_q;
    qbit    = (rem_sh >= {1'b0, dvs_q});
    q_fin   = {dvd_q[DIV_BITS-2:0], qbit};
    q_big   = |q_fin[DIV_BITS-1:31];
    if (w_cur == 32'd0) begin
      // The divider output is meaningless here; the answer depends only on n.
      if (n_cur == 32'd0)  res = 32'h0000_0000;
      else if (n_cur[31])  res = 32'h8000_0000;
      else                 res = 32'h7FFF_FFFF;
    end else if (q_big) begin
      // Also covers a negative magnitude of exactly 2^31, which is representable.
      res = sign_q ? 32'h8000_0000 : 32'h7FFF_FFFF;
    end else begin
      res = sign_q ? (~q_fin[31:0] + 32'd1) : q_fin[31:0];
    end
  end

  // Next-state and datapath updates for the IDLE/PREP/DIV/OUT sequence.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    w_d     = w_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    rem_d   = rem_q;
    sign_d  = sign_q;
    sx_d    = sx_q;
    sy_d    = sy_q;
    sz_d    = sz_q;
    clip_d  = clip_q;
    valid_d = valid_q;
    stall_d = stall_q;
    done_d  = done_q;
    case (state_q)
      IDLE: begin
        // Right after reset stall_out is still high, so that cycle never accepts.
        if (bus.in_data_valid && !stall_q) begin
          x_d     = bus.x_in[2:0];
          y_d     = bus.y_in[2:0];
          z_d     = bus.z_in[2:0];
          w_d     = bus.w_in[2:0];
          clip_d  = bus.w_in[0][31] | (bus.w_in[0] == 32'd0) |
                    bus.w_in[1][31] | (bus.w_in[1] == 32'd0) |
                    bus.w_in[2][31] | (bus.w_in[2] == 32'd0);
          k_d     = 4'd0;
          stall_d = 1'b1;
          state_d = PREP;
        end else begin
          stall_d = 1'b0;
        end
        if (bus.done_in && !bus.in_data_valid) done_d = 1'b1;
      end
      PREP: begin
        dvd_d   = DIV_BITS'({n_mag, 16'h0000});
        dvs_d   = w_mag;
        rem_d   = 32'd0;
        sign_d  = n_cur[31] ^ w_cur[31];
        cnt_d   = 6'd0;
        state_d = DIV;
      end
      DIV: begin
        rem_d = qbit ? rem_sub : rem_sh[31:0];
        dvd_d = q_fin;
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'(DIV_BITS - 1)) begin
          case (csel)
            2'd0:    sx_d[vsel] = res;
            2'd1:    sy_d[vsel] = res;
            default: sz_d[vsel] = res;
          endcase
          if (k_q == 4'd8) begin
            valid_d = 1'b1;
            state_d = OUT;
          end else begin
            k_d     = k_q + 4'd1;
            state_d = PREP;
          end
        end
      end
      OUT: begin
        if (!bus.stall_in) begin
          valid_d = 1'b0;
          stall_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset discards any triangle in flight.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= IDLE;
      k_q     <= 4'd0;
      cnt_q   <= 6'd0;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      w_q     <= '0;
      dvd_q   <= '0;
      dvs_q   <= 32'd0;
      rem_q   <= 32'd0;
      sign_q  <= 1'b0;
      sx_q    <= '0;
      sy_q    <= '0;
      sz_q    <= '0;
      clip_q  <= 1'b0;
      valid_q <= 1'b0;
      stall_q <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      w_q     <= w_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
      sign_q  <= sign_d;
      sx_q    <= sx_d;
      sy_q    <= sy_d;
      sz_q    <= sz_d;
      clip_q  <= clip_d;
      valid_q <= valid_d;
      stall_q <= stall_d;
      done_q  <= done_d;
    end
  end

  assign bus.sx_out         = sx_q;
  assign bus.sy_out         = sy_q;
  assign bus.sz_out         = sz_q;
  assign bus.clip_out       = clip_q;
  assign bus.out_data_valid = valid_q;
  assign bus.stall_out      = stall_q;
  assign bus.done_out       = done_q;
endmodule
